kws_alert_ctrl: RTL and testbench

KWS_ALERT_CTRL -- requirements
Module: kws_alert_ctrl

---
 rtl/kws_alert_pkg.sv | 16 +
 rtl/kws_tone_gen.sv | 31 +++
 rtl/kws_alert_ctrl.sv | 160 ++++++++++++++++
 tb/tb_kws_alert_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kws_alert_pkg.sv
// Shared types and default constants for the keyword-spotting alert controller.
package kws_alert_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEEP,
    HOLD
  } state_t;

  localparam logic [15:0] DEF_THR_PRV  = 16'd6500;
  localparam logic [15:0] DEF_THR_PUB  = 16'd4000;
  localparam int          DEF_BEEP_CYC = 50000000;
  localparam int          DEF_HOLD_CYC = 12500000;
  localparam int          DEF_TONE_DIV = 12500;

endpackage

// File: rtl/kws_tone_gen.sv
// Tone/bit-period timebase: tick every TONE_DIV enabled cycles, square toggles on each tick.
// Disabling restarts the period with square low.
module kws_tone_gen #(
  parameter int TONE_DIV = 12500
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick,
  output logic square
);

  localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TONE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt    <= '0;
      square <= 1'b0;
    end else if (tick) begin
      cnt    <= '0;
      square <= ~square;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/kws_alert_ctrl.sv
// Alert controller: debounces detector hits per channel, then beeps and holds off.
// Optional score serialiser on led_scr is enabled by defining KWS_ALERT_SCR_SERIAL_EN.
module kws_alert_ctrl
  import kws_alert_pkg::*;
#(
  parameter int          NCH      = 2,
  parameter int          HITS     = 2,
  parameter int          BEEP_CYC = DEF_BEEP_CYC,
  parameter int          HOLD_CYC = DEF_HOLD_CYC,
  parameter int          TONE_DIV = DEF_TONE_DIV,
  parameter int          SCR_W    = 24,
  parameter logic [15:0] THR_PRV  = DEF_THR_PRV,
  parameter logic [15:0] THR_PUB  = DEF_THR_PUB
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 switch,
  input  logic [NCH-1:0]                       det_dv,
  input  logic [NCH-1:0]                       det,
  input  logic [NCH*SCR_W-1:0]                 scr,
  output logic [15:0]                          thr_o,
  output logic                                 beep,
  output logic                                 alert,
  output logic [(NCH>1 ? $clog2(NCH) : 1)-1:0] alert_ch,
  output logic [NCH-1:0]                       led_det,
  output logic                                 led_scr
);

  localparam int         AW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int         DMAX   = (BEEP_CYC > HOLD_CYC) ? BEEP_CYC : HOLD_CYC;
  localparam int         DW     = $clog2(DMAX) + 1;
  localparam logic [3:0] HITS_V = 4'(HITS);

  state_t        state;
  logic [DW-1:0] dur;
  logic [3:0]    hit_cnt [NCH];
  logic          hit_any;
  logic [AW-1:0] sel;
  logic          fire;
  logic          tone_en;
  logic          tone_tick;
  logic          tone_sq;

  // Descending scan so the lowest ready channel is the one left in sel.
  always_comb begin
    hit_any = 1'b0;
    sel     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit_cnt[i] == HITS_V) begin
        hit_any = 1'b1;
        sel     = AW'(i);
      end
    end
  end

  assign fire = (state == IDLE) && hit_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) hit_cnt[i] <= '0;
      led_det <= '0;
      thr_o   <= THR_PUB;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (fire)
          hit_cnt[i] <= '0;
        else if (det_dv[i])
          hit_cnt[i] <= !det[i] ? 4'd0 :
                        (hit_cnt[i] == HITS_V) ? HITS_V : hit_cnt[i] + 4'd1;
        if (det_dv[i]) led_det[i] <= det[i];
      end
      thr_o <= switch ? THR_PRV : THR_PUB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dur      <= '0;
      alert    <= 1'b0;
      alert_ch <= '0;
    end else begin
      alert <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            state    <= BEEP;
            dur      <= '0;
            alert    <= 1'b1;
            alert_ch <= sel;
          end
        end
        BEEP: begin
          if (dur == DW'(BEEP_CYC - 1)) begin
            state <= HOLD;
            dur   <= '0;
          end else begin
            dur <= dur + DW'(1);
          end
        end
        HOLD: begin
          if (dur == DW'(HOLD_CYC - 1)) begin
            state <= IDLE;
            dur   <= '0;
          end else begin
            dur <= dur + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          dur   <= '0;
        end
      endcase
    end
  end

  assign beep = tone_sq && (state == BEEP);

  kws_tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk   (clk),
    .reset (reset),
    .en    (tone_en),
    .tick  (tone_tick),
    .square(tone_sq)
  );

`ifdef KWS_ALERT_SCR_SERIAL_EN
  localparam int PW = $clog2(SCR_W + 4);

  logic [SCR_W-1:0] scr_lat;
  logic [PW-1:0]    pos;

  // Timebase also paces the serialiser in IDLE; it drops for the trigger cycle so BEEP starts low.
  assign tone_en = (state == BEEP) || ((state == IDLE) && !fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      scr_lat <= '0;
      pos     <= '0;
      led_scr <= 1'b0;
    end else begin
      if (fire) scr_lat <= scr[int'(sel)*SCR_W +: SCR_W];
      if (state != IDLE)
        pos <= '0;
      else if (tone_tick)
        pos <= (pos == PW'(SCR_W + 3)) ? '0 : pos + PW'(1);
      led_scr <= (state == IDLE) && (int'(pos) < SCR_W) && scr_lat[SCR_W - 1 - int'(pos)];
    end
  end
`else
  logic unused_inputs;

  assign tone_en       = (state == BEEP);
  assign led_scr       = 1'b0;
  assign unused_inputs = ^{scr, tone_tick};
`endif

endmodule

// File: tb/tb_kws_alert_ctrl.sv
// Scoreboard bench for kws_alert_ctrl with shortened beep/hold/tone timing.
// Expects the default build unless KWS_ALERT_SCR_SERIAL_EN is defined for both files.
module tb_kws_alert_ctrl;

`ifdef KWS_ALERT_SCR_SERIAL_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        switch;
  logic [1:0]  det_dv;
  logic [1:0]  det;
  logic [47:0] scr;
  logic [15:0] thr_o;
  logic        beep;
  logic        alert;
  logic [0:0]  alert_ch;
  logic [1:0]  led_det;
  logic        led_scr;

  int cyc          = 0;
  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  kws_alert_ctrl #(
    .NCH     (2),
    .HITS    (2),
    .BEEP_CYC(100),
    .HOLD_CYC(50),
    .TONE_DIV(10),
    .SCR_W   (24),
    .THR_PRV (16'd6500),
    .THR_PUB (16'd4000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .switch  (switch),
    .det_dv  (det_dv),
    .det     (det),
    .scr     (scr),
    .thr_o   (thr_o),
    .beep    (beep),
    .alert   (alert),
    .alert_ch(alert_ch),
    .led_det (led_det),
    .led_scr (led_scr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Each alert pulse must match the oldest expected (channel, cycle) entry.
  always @(negedge clk) begin
    if (alert === 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL alert_unexpected: got alert ch %0d at cycle %0d, required no alert", alert_ch, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (int'(alert_ch) != mon_e.ch || cyc != mon_e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL alert: got ch %0d at cycle %0d, required ch %0d at cycle %0d",
                   alert_ch, cyc, mon_e.ch, mon_e.cyc);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic at_cycle(input int t);
    if (cyc > t) begin
      $display("[TB] FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, t);
      $fatal(1, "[TB] schedule overrun");
    end
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] dv, input logic [1:0] d);
    det_dv = dv;
    det    = d;
    @(posedge clk);
    #1;
    det_dv = '0;
    det    = '0;
  endtask

  task automatic push_alert(input int ch, input int at);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  initial begin
    int          toggles;
    logic        prev;
    logic        exp_bit;
    logic [23:0] word;
    int          ks[8];
    int          p;

    reset  = 1'b1;
    switch = 1'b1;
    det_dv = '0;
    det    = '0;
    scr    = {24'hA00001, 24'h123456};
    word   = 24'hA00001;
    ks     = '{0, 1, 2, 3, 23, 24, 27, 28};

    // Reset values, with switch high to show reset overrides it.
    at_cycle(3);
    @(negedge clk);
    check_output("rst_thr_o", 32'(thr_o), 32'd4000);
    check_output("rst_beep", 32'(beep), 32'd0);
    check_output("rst_alert", 32'(alert), 32'd0);
    check_output("rst_alert_ch", 32'(alert_ch), 32'd0);
    check_output("rst_led_det", 32'(led_det), 32'd0);
    check_output("rst_led_scr", 32'(led_scr), 32'd0);
    at_cycle(4);
    switch = 1'b0;
    reset  = 1'b0;

    // Hit, miss, hit on ch0 must not alert; one more hit does.
    at_cycle(6);
    apply_stimulus(2'b01, 2'b01);
    @(negedge clk);
    check_output("led_det_hit", 32'(led_det), 32'd1);
    at_cycle(8);
    apply_stimulus(2'b01, 2'b00);
    @(negedge clk);
    check_output("led_det_miss", 32'(led_det), 32'd0);
    at_cycle(10);
    apply_stimulus(2'b11, 2'b01);
    @(negedge clk);
    check_output("led_det_both", 32'(led_det), 32'd1);
    at_cycle(12);
    push_alert(0, 14);
    apply_stimulus(2'b01, 2'b11);
    @(negedge clk);
    check_output("led_det_hold", 32'(led_det), 32'd1);

    // Beep waveform over the alert at cycle 14: 10-cycle half periods, starting low.
    toggles = 0;
    prev    = 1'b0;
    for (int k = 0; k <= 104; k++) begin
      at_cycle(14 + k);
      @(negedge clk);
      if (k == 0)
        prev = beep;
      else if (beep !== prev) begin
        toggles++;
        prev = beep;
      end
      if (k == 0 || k == 9 || k == 10 || k == 99 || k == 100)
        check_output($sformatf("beep_k%0d", k), 32'(beep),
                     32'((k < 100) && (((k / 10) % 2) == 1)));
    end
    check_output("beep_toggles", 32'(toggles), 32'd10);

    // Two ch0 hits during HOLD (cycles 114..163) fire on the first IDLE cycle.
    at_cycle(150);
    apply_stimulus(2'b01, 2'b01);
    at_cycle(152);
    push_alert(0, 165);
    apply_stimulus(2'b01, 2'b01);

    // Ch1 alert; switch changes mid-BEEP only move thr_o.
    at_cycle(320);
    apply_stimulus(2'b10, 2'b10);
    at_cycle(322);
    push_alert(1, 324);
    apply_stimulus(2'b10, 2'b10);
    at_cycle(340);
    switch = 1'b1;
    @(negedge clk);
    check_output("thr_o_pre_switch", 32'(thr_o), 32'd4000);
    at_cycle(341);
    @(negedge clk);
    check_output("thr_o_private", 32'(thr_o), 32'd6500);
    at_cycle(360);
    switch = 1'b0;
    at_cycle(361);
    @(negedge clk);
    check_output("thr_o_public", 32'(thr_o), 32'd4000);
    at_cycle(414);
    @(negedge clk);
    check_output("beep_after_switch", 32'(beep), 32'd1);
    at_cycle(424);
    @(negedge clk);
    check_output("beep_end_after_switch", 32'(beep), 32'd0);

    // Simultaneous hits: ch0 wins and ch1 must not retrigger after HOLD.
    at_cycle(480);
    apply_stimulus(2'b11, 2'b11);
    at_cycle(482);
    push_alert(0, 484);
    apply_stimulus(2'b11, 2'b11);

    // Reset in BEEP cycle 37 aborts the alert.
    at_cycle(640);
    apply_stimulus(2'b10, 2'b10);
    at_cycle(642);
    push_alert(1, 644);
    apply_stimulus(2'b10, 2'b10);
    at_cycle(680);
    @(negedge clk);
    check_output("beep_k36", 32'(beep), 32'd1);
    at_cycle(681);
    reset = 1'b1;
    @(negedge clk);
    check_output("beep_k37", 32'(beep), 32'd1);
    at_cycle(682);
    reset = 1'b0;
    @(negedge clk);
    check_output("beep_after_reset", 32'(beep), 32'd0);
    check_output("alert_ch_after_reset", 32'(alert_ch), 32'd0);
    check_output("led_det_after_reset", 32'(led_det), 32'd0);

    // Back in IDLE: a fresh ch1 alert latches score A00001.
    at_cycle(684);
    apply_stimulus(2'b10, 2'b10);
    at_cycle(686);
    push_alert(1, 688);
    apply_stimulus(2'b10, 2'b10);

    // First IDLE cycle is 838; serial bit k is mid-window at cycle 843 + 10k.
    for (int i = 0; i < 8; i++) begin
      at_cycle(843 + 10 * ks[i]);
      @(negedge clk);
      p       = ks[i] % 28;
      exp_bit = SERIAL && (p < 24) && word[23 - p];
      check_output($sformatf("led_scr_bit%0d", ks[i]), 32'(led_scr), 32'(exp_bit));
    end

    at_cycle(1130);
    @(negedge clk);
    check_output("alerts_pending", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
